// File: rtl/io_pinmux_wb_if.sv
// Wishbone slave bundle for the IO pad multiplexer.
// Byte-addressed, 32-bit data, single-cycle ack.
interface io_pinmux_wb_if;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (
    output stb, cyc, we, sel, adr, dat_w,
    input  ack, dat_r
  );

  modport slave (
    input  stb, cyc, we, sel, adr, dat_w,
    output ack, dat_r
  );
endinterface

// File: rtl/io_pinmux_wb.sv
// Wishbone-configurable pad multiplexer: per-pad function select,
// GPIO bank, synchronised input sampling and rising-edge interrupts.
module io_pinmux_wb #(
  parameter int          NPADS       = 38,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  io_pinmux_wb_if.slave        wbs,
  input  logic [3*NPADS-1:0]   func_out,
  input  logic [3*NPADS-1:0]   func_oeb,
  output logic [NPADS-1:0]     func_in,
  input  logic [NPADS-1:0]     io_in,
  output logic [NPADS-1:0]     io_out,
  output logic [NPADS-1:0]     io_oeb,
  output logic                 irq
);

  logic [NPADS-1:0]   gpio_out;
  logic [NPADS-1:0]   gpio_oeb;
  logic [NPADS-1:0]   ie;
  logic [NPADS-1:0]   is_q;
  logic [2*NPADS-1:0] sel_q;
  logic [SYNC_STAGES-1:0][NPADS-1:0] sync_q;
  logic [NPADS-1:0]   prev_q;
  logic [NPADS-1:0]   rise;

  logic [63:0]  out64, oeb64, in64, ie64, is64;
  logic [127:0] sel128;
  logic [63:0]  out_n, oeb_n, ie_n, is_n, clr64, set64;
  logic [127:0] sel_n;

  logic        req, hit, wr;
  logic [7:0]  off;
  logic [31:0] bm, wd, rdata;
  logic        unused_bits;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [31:0] m
  );
    return (old & ~m) | (nw & m);
  endfunction

  assign req = wbs.stb & wbs.cyc & ~wbs.ack;
  assign hit = wbs.adr[31:8] == BASE_ADDR[31:8];
  assign off = wbs.adr[7:0];
  assign wr  = req & wbs.we & hit;
  assign bm  = {{8{wbs.sel[3]}}, {8{wbs.sel[2]}},
                {8{wbs.sel[1]}}, {8{wbs.sel[0]}}};
  assign wd  = wbs.dat_w & bm;

  assign func_in = io_in;
  assign rise    = sync_q[SYNC_STAGES-1] & ~prev_q & ie;

  // Zero-extended 64-pad views keep the register map independent of NPADS.
  always_comb begin
    out64  = '0;
    oeb64  = '0;
    in64   = '0;
    ie64   = '0;
    is64   = '0;
    sel128 = '0;
    set64  = '0;
    out64[NPADS-1:0]    = gpio_out;
    oeb64[NPADS-1:0]    = gpio_oeb;
    in64[NPADS-1:0]     = sync_q[SYNC_STAGES-1];
    ie64[NPADS-1:0]     = ie;
    is64[NPADS-1:0]     = is_q;
    sel128[2*NPADS-1:0] = sel_q;
    set64[NPADS-1:0]    = rise;
  end

  always_comb begin
    out_n = out64;
    oeb_n = oeb64;
    ie_n  = ie64;
    sel_n = sel128;
    clr64 = '0;
    if (wr) begin
      unique case (off)
        8'h00: out_n[31:0]  = merge(out64[31:0], wbs.dat_w, bm);
        8'h04: out_n[63:32] = merge(out64[63:32], wbs.dat_w, bm);
        8'h08: oeb_n[31:0]  = merge(oeb64[31:0], wbs.dat_w, bm);
        8'h0C: oeb_n[63:32] = merge(oeb64[63:32], wbs.dat_w, bm);
        8'h18: ie_n[31:0]   = merge(ie64[31:0], wbs.dat_w, bm);
        8'h1C: ie_n[63:32]  = merge(ie64[63:32], wbs.dat_w, bm);
        8'h20: clr64[31:0]  = wd;
        8'h24: clr64[63:32] = wd;
        8'h40: sel_n[31:0]   = merge(sel128[31:0], wbs.dat_w, bm);
        8'h44: sel_n[63:32]  = merge(sel128[63:32], wbs.dat_w, bm);
        8'h48: sel_n[95:64]  = merge(sel128[95:64], wbs.dat_w, bm);
        8'h4C: sel_n[127:96] = merge(sel128[127:96], wbs.dat_w, bm);
        default: ;
      endcase
    end
    // A new edge in the same cycle as a W1C keeps the bit set.
    is_n = (is64 & ~clr64) | set64;
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      unique case (off)
        8'h00: rdata = out64[31:0];
        8'h04: rdata = out64[63:32];
        8'h08: rdata = oeb64[31:0];
        8'h0C: rdata = oeb64[63:32];
        8'h10: rdata = in64[31:0];
        8'h14: rdata = in64[63:32];
        8'h18: rdata = ie64[31:0];
        8'h1C: rdata = ie64[63:32];
        8'h20: rdata = is64[31:0];
        8'h24: rdata = is64[63:32];
        8'h40: rdata = sel128[31:0];
        8'h44: rdata = sel128[63:32];
        8'h48: rdata = sel128[95:64];
        8'h4C: rdata = sel128[127:96];
        default: rdata = '0;
      endcase
    end
  end

  assign unused_bits = ^{out_n, oeb_n, ie_n, is_n, sel_n};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs.ack   <= 1'b0;
      wbs.dat_r <= '0;
      gpio_out  <= '0;
      gpio_oeb  <= '1;
      ie        <= '0;
      is_q      <= '0;
      sel_q     <= '0;
      sync_q    <= '0;
      prev_q    <= '0;
      irq       <= 1'b0;
    end else begin
      wbs.ack   <= req;
      wbs.dat_r <= req ? rdata : '0;
      gpio_out  <= out_n[NPADS-1:0];
      gpio_oeb  <= oeb_n[NPADS-1:0];
      ie        <= ie_n[NPADS-1:0];
      is_q      <= is_n[NPADS-1:0];
      sel_q     <= sel_n[2*NPADS-1:0];
      sync_q    <= {sync_q[SYNC_STAGES-2:0], io_in};
      prev_q    <= sync_q[SYNC_STAGES-1];
      irq       <= |is_q;
    end
  end

  always_comb begin
    io_out = gpio_out;
    io_oeb = gpio_oeb;
    for (int i = 0; i < NPADS; i++) begin
      for (int f = 0; f < 3; f++) begin
        if (sel_q[2*i +: 2] == 2'(f + 1)) begin
          io_out[i] = func_out[f*NPADS + i];
          io_oeb[i] = func_oeb[f*NPADS + i];
        end
      end
    end
  end

endmodule
